openofdm_rx_pkt_ctrl: RTL and testbench

Per-packet reception sequencer for the OFDM receive core. It tracks each packet from short-preamble detection through FCS and enforces per-stage timeouts counted in input samples. It validates the decoded header and issues a bounded soft-reset pulse to the receiver core whenever a packet stalls or is rejected. It sits beside the receiver core in the receive top level: it consumes the core's status outputs, and its `core_rst` is ORed into the core reset.

---
 rtl/openofdm_rx_pkt_ctrl.sv | 256 +++++++++++++++++++++++++
 tb/tb_openofdm_rx_pkt_ctrl.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/openofdm_rx_pkt_ctrl.sv
// Per-packet RX sequencer: preamble -> header -> data -> FCS, with sample-based stage timeouts and core soft reset.
// Latency: every output is registered; a decision on inputs sampled at edge N is visible after edge N.
// Backpressure: none; status inputs are strobes/levels from the receiver core and are never stalled.
//
// Ports:
//   s00_axi_aclk / s00_axi_aresetn : clock, asynchronous active-low reset
//   enable, clear_cnt              : sequencer enable (0 forces IDLE), statistics clear pulse
//   sample_in_strobe               : timeout time base (one tick per input sample)
//   short/long_preamble_detected   : core preamble status levels
//   pkt_header_*, ht_unsupport,
//   pkt_len                        : header decode result, qualified by pkt_header_valid_strobe
//   byte_out_strobe, byte_count    : decoded data progress
//   fcs_out_strobe, fcs_ok         : end-of-packet FCS result
//   cfg_*                          : stage timeouts in samples (0 disables) and maximum packet length
//   core_rst                       : active-high soft reset to the receiver core, RST_CYCLES long
//   rx_busy, state, abort_code     : sequencer status
//   pkt_done_strobe, cnt_*         : end-of-packet pulse and saturating statistics counters
module openofdm_rx_pkt_ctrl #(
    parameter int RST_CYCLES = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 s00_axi_aclk,
    input  logic                 s00_axi_aresetn,
    input  logic                 enable,
    input  logic                 clear_cnt,
    input  logic                 sample_in_strobe,
    input  logic                 short_preamble_detected,
    input  logic                 long_preamble_detected,
    input  logic                 pkt_header_valid,
    input  logic                 pkt_header_valid_strobe,
    input  logic                 ht_unsupport,
    input  logic [15:0]          pkt_len,
    input  logic                 byte_out_strobe,
    input  logic [15:0]          byte_count,
    input  logic                 fcs_out_strobe,
    input  logic                 fcs_ok,
    input  logic [15:0]          cfg_lts_timeout,
    input  logic [15:0]          cfg_hdr_timeout,
    input  logic [15:0]          cfg_byte_timeout,
    input  logic [15:0]          cfg_max_len,
    output logic                 core_rst,
    output logic                 rx_busy,
    output logic [2:0]           state,
    output logic [2:0]           abort_code,
    output logic                 pkt_done_strobe,
    output logic [CNT_WIDTH-1:0] cnt_fcs_ok,
    output logic [CNT_WIDTH-1:0] cnt_fcs_err,
    output logic [CNT_WIDTH-1:0] cnt_abort
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LTS_WAIT = 3'd1,
        ST_HDR_WAIT = 3'd2,
        ST_DATA     = 3'd3,
        ST_RESET    = 3'd4
    } state_t;

    // Abort reasons reported on abort_code.
    localparam logic [2:0] AB_LTS_TIMEOUT  = 3'd1;
    localparam logic [2:0] AB_HDR_INVALID  = 3'd2;
    localparam logic [2:0] AB_HT_UNSUPPORT = 3'd3;
    localparam logic [2:0] AB_BAD_LEN      = 3'd4;
    localparam logic [2:0] AB_HDR_TIMEOUT  = 3'd5;
    localparam logic [2:0] AB_BYTE_TIMEOUT = 3'd6;
    localparam logic [2:0] AB_LEN_OVERRUN  = 3'd7;

    // The RESET dwell counter loads RST_CYCLES-1 on entry and leaves when it reaches 0,
    // so the state (and core_rst) stays in RESET for exactly RST_CYCLES cycles.
    localparam int             RW       = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [RW-1:0]  RST_LOAD = RW'(RST_CYCLES - 1);

    state_t                 state_q, state_d;
    logic [15:0]            timer_q, timer_d;
    logic [RW-1:0]          rst_cnt_q;
    logic [15:0]            len_q;
    logic [2:0]             abort_code_q, abort_d;
    logic                   core_rst_q;
    logic                   rx_busy_q;
    logic                   pkt_done_q;
    logic [CNT_WIDTH-1:0]   cnt_ok_q, cnt_err_q, cnt_abort_q;

    logic                   abort_take;
    logic                   fcs_evt;
    logic                   len_ld;
    logic [15:0]            timeout_lim;
    logic                   timeout;
    logic                   len_overrun;

    // Each waiting state has its own limit; a zero limit disables the timeout.
    always_comb begin
        timeout_lim = 16'd0;
        case (state_q)
            ST_LTS_WAIT: timeout_lim = cfg_lts_timeout;
            ST_HDR_WAIT: timeout_lim = cfg_hdr_timeout;
            ST_DATA:     timeout_lim = cfg_byte_timeout;
            default:     timeout_lim = 16'd0;
        endcase
    end

    assign timeout = (timeout_lim != 16'd0) && (timer_q >= timeout_lim);

    // The core may emit the 4 FCS bytes after the payload, hence the +4 slack.
    assign len_overrun = {1'b0, byte_count} > ({1'b0, len_q} + 17'd4);

    // Next-state logic. Within each state, real events are tested before the
    // timeout so that an event arriving on the timeout cycle wins.
    always_comb begin
        state_d    = state_q;
        abort_take = 1'b0;
        abort_d    = abort_code_q;
        fcs_evt    = 1'b0;
        len_ld     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (short_preamble_detected) begin
                    state_d = ST_LTS_WAIT;
                end
            end
            ST_LTS_WAIT: begin
                if (long_preamble_detected) begin
                    state_d = ST_HDR_WAIT;
                end else if (timeout) begin
                    abort_take = 1'b1;
                    abort_d    = AB_LTS_TIMEOUT;
                end
            end
            ST_HDR_WAIT: begin
                if (pkt_header_valid_strobe) begin
                    if (!pkt_header_valid) begin
                        abort_take = 1'b1;
                        abort_d    = AB_HDR_INVALID;
                    end else if (ht_unsupport) begin
                        abort_take = 1'b1;
                        abort_d    = AB_HT_UNSUPPORT;
                    end else if ((pkt_len == 16'd0) || (pkt_len > cfg_max_len)) begin
                        abort_take = 1'b1;
                        abort_d    = AB_BAD_LEN;
                    end else begin
                        len_ld  = 1'b1;
                        state_d = ST_DATA;
                    end
                end else if (timeout) begin
                    abort_take = 1'b1;
                    abort_d    = AB_HDR_TIMEOUT;
                end
            end
            ST_DATA: begin
                if (fcs_out_strobe) begin
                    fcs_evt = 1'b1;
                    state_d = ST_IDLE;
                end else if (len_overrun) begin
                    abort_take = 1'b1;
                    abort_d    = AB_LEN_OVERRUN;
                end else if (timeout) begin
                    abort_take = 1'b1;
                    abort_d    = AB_BYTE_TIMEOUT;
                end
            end
            ST_RESET: begin
                // Core status is ignored here; only the dwell counter matters.
                if (rst_cnt_q == '0) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (abort_take) begin
            state_d = ST_RESET;
        end

        // Disable overrides everything, including a pending abort or FCS event.
        if (!enable) begin
            state_d    = ST_IDLE;
            abort_take = 1'b0;
            abort_d    = abort_code_q;
            fcs_evt    = 1'b0;
            len_ld     = 1'b0;
        end
    end

    // Timer restarts on every state change and, in DATA, on each decoded byte.
    always_comb begin
        timer_d = timer_q;
        if ((state_d != state_q) || ((state_q == ST_DATA) && byte_out_strobe)) begin
            timer_d = 16'd0;
        end else if (sample_in_strobe && (timer_q != 16'hFFFF)) begin
            timer_d = timer_q + 16'd1;
        end
    end

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            state_q      <= ST_IDLE;
            timer_q      <= 16'd0;
            rst_cnt_q    <= '0;
            len_q        <= 16'd0;
            abort_code_q <= 3'd0;
            core_rst_q   <= 1'b0;
            rx_busy_q    <= 1'b0;
            pkt_done_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            abort_code_q <= abort_d;
            core_rst_q   <= (state_d == ST_RESET);
            rx_busy_q    <= (state_d != ST_IDLE);
            pkt_done_q   <= fcs_evt;
            if (len_ld) begin
                len_q <= pkt_len;
            end
            if (abort_take) begin
                rst_cnt_q <= RST_LOAD;
            end else if ((state_q == ST_RESET) && (rst_cnt_q != '0)) begin
                rst_cnt_q <= rst_cnt_q - 1'b1;
            end
        end
    end

    // Statistics counters: saturate at all-ones; a coincident clear wins.
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            cnt_ok_q    <= '0;
            cnt_err_q   <= '0;
            cnt_abort_q <= '0;
        end else if (clear_cnt) begin
            cnt_ok_q    <= '0;
            cnt_err_q   <= '0;
            cnt_abort_q <= '0;
        end else begin
            if (fcs_evt && fcs_ok && !(&cnt_ok_q)) begin
                cnt_ok_q <= cnt_ok_q + 1'b1;
            end
            if (fcs_evt && !fcs_ok && !(&cnt_err_q)) begin
                cnt_err_q <= cnt_err_q + 1'b1;
            end
            if (abort_take && !(&cnt_abort_q)) begin
                cnt_abort_q <= cnt_abort_q + 1'b1;
            end
        end
    end

    assign core_rst        = core_rst_q;
    assign rx_busy         = rx_busy_q;
    assign state           = state_q;
    assign abort_code      = abort_code_q;
    assign pkt_done_strobe = pkt_done_q;
    assign cnt_fcs_ok      = cnt_ok_q;
    assign cnt_fcs_err     = cnt_err_q;
    assign cnt_abort       = cnt_abort_q;

endmodule

// File: tb/tb_openofdm_rx_pkt_ctrl.sv
// Directed bench for openofdm_rx_pkt_ctrl: good packet, every abort path, boundary timeouts,
// coincident events, counter clear, enable drop and asynchronous reset.
// Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
module tb_openofdm_rx_pkt_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        clear_cnt = 1'b0;
    logic        sample_in_strobe = 1'b0;
    logic        short_preamble_detected = 1'b0;
    logic        long_preamble_detected = 1'b0;
    logic        pkt_header_valid = 1'b0;
    logic        pkt_header_valid_strobe = 1'b0;
    logic        ht_unsupport = 1'b0;
    logic [15:0] pkt_len = 16'd0;
    logic        byte_out_strobe = 1'b0;
    logic [15:0] byte_count = 16'd0;
    logic        fcs_out_strobe = 1'b0;
    logic        fcs_ok = 1'b0;
    logic [15:0] cfg_lts_timeout = 16'd160;
    logic [15:0] cfg_hdr_timeout = 16'd200;
    logic [15:0] cfg_byte_timeout = 16'd400;
    logic [15:0] cfg_max_len = 16'd4095;
    logic        core_rst;
    logic        rx_busy;
    logic [2:0]  state;
    logic [2:0]  abort_code;
    logic        pkt_done_strobe;
    logic [15:0] cnt_fcs_ok;
    logic [15:0] cnt_fcs_err;
    logic [15:0] cnt_abort;

    int checks = 0;
    int errors = 0;
    bit rst_seen = 1'b0;

    openofdm_rx_pkt_ctrl #(.RST_CYCLES(4), .CNT_WIDTH(16)) dut (
        .s00_axi_aclk            (clk),
        .s00_axi_aresetn         (rst_n),
        .enable                  (enable),
        .clear_cnt               (clear_cnt),
        .sample_in_strobe        (sample_in_strobe),
        .short_preamble_detected (short_preamble_detected),
        .long_preamble_detected  (long_preamble_detected),
        .pkt_header_valid        (pkt_header_valid),
        .pkt_header_valid_strobe (pkt_header_valid_strobe),
        .ht_unsupport            (ht_unsupport),
        .pkt_len                 (pkt_len),
        .byte_out_strobe         (byte_out_strobe),
        .byte_count              (byte_count),
        .fcs_out_strobe          (fcs_out_strobe),
        .fcs_ok                  (fcs_ok),
        .cfg_lts_timeout         (cfg_lts_timeout),
        .cfg_hdr_timeout         (cfg_hdr_timeout),
        .cfg_byte_timeout        (cfg_byte_timeout),
        .cfg_max_len             (cfg_max_len),
        .core_rst                (core_rst),
        .rx_busy                 (rx_busy),
        .state                   (state),
        .abort_code              (abort_code),
        .pkt_done_strobe         (pkt_done_strobe),
        .cnt_fcs_ok              (cnt_fcs_ok),
        .cnt_fcs_err             (cnt_fcs_err),
        .cnt_abort               (cnt_abort)
    );

    always #5 clk = ~clk;

    // Advance one edge; remember whether core_rst was ever seen high.
    task automatic tick();
        @(posedge clk);
        #1;
        if (core_rst) rst_seen = 1'b1;
    endtask

    task automatic go_to_hdr();
        short_preamble_detected = 1'b1;
        tick();
        short_preamble_detected = 1'b0;
        long_preamble_detected = 1'b1;
        tick();
        long_preamble_detected = 1'b0;
    endtask

    task automatic send_header(input logic valid, input logic ht, input logic [15:0] len);
        pkt_header_valid = valid;
        ht_unsupport = ht;
        pkt_len = len;
        pkt_header_valid_strobe = 1'b1;
        tick();
        pkt_header_valid_strobe = 1'b0;
        ht_unsupport = 1'b0;
    endtask

    task automatic send_bytes(input int first, input int n);
        for (int i = 0; i < n; i++) begin
            byte_count = 16'(first + i);
            byte_out_strobe = 1'b1;
            tick();
        end
        byte_out_strobe = 1'b0;
    endtask

    task automatic run_samples(input int n);
        sample_in_strobe = 1'b1;
        repeat (n) tick();
        sample_in_strobe = 1'b0;
    endtask

    // Waits (bounded) for IDLE with core_rst low; reports whether it got there.
    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (state == 3'd0 && !core_rst) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if ({state, core_rst, rx_busy, abort_code, pkt_done_strobe} !== 9'd0) begin
            errors++; $display("FAIL reset_outputs: got state=%0d core_rst=%0b busy=%0b code=%0d done=%0b, want all 0",
                               state, core_rst, rx_busy, abort_code, pkt_done_strobe);
        end
        checks++; if ({cnt_fcs_ok, cnt_fcs_err, cnt_abort} !== 48'd0) begin
            errors++; $display("FAIL reset_counters: got ok=%0d err=%0d abort=%0d, want 0", cnt_fcs_ok, cnt_fcs_err, cnt_abort);
        end
        #3 rst_n = 1'b1;
        enable = 1'b1;
        tick();
        checks++; if (state !== 3'd0) begin
            errors++; $display("FAIL idle_after_reset: state=%0d want 0", state);
        end
    endtask

    task automatic test_good_packet();
        rst_seen = 1'b0;
        byte_count = 16'd0;
        go_to_hdr();
        checks++; if (state !== 3'd2) begin
            errors++; $display("FAIL good_hdr_wait: state=%0d want 2", state);
        end
        send_header(1'b1, 1'b0, 16'd100);
        checks++; if (state !== 3'd3 || rx_busy !== 1'b1) begin
            errors++; $display("FAIL good_data: state=%0d busy=%0b want 3/1", state, rx_busy);
        end
        send_bytes(1, 100);
        fcs_out_strobe = 1'b1;
        fcs_ok = 1'b1;
        tick();
        fcs_out_strobe = 1'b0;
        checks++; if (pkt_done_strobe !== 1'b1 || cnt_fcs_ok !== 16'd1 || state !== 3'd0 || rx_busy !== 1'b0) begin
            errors++; $display("FAIL good_done: done=%0b ok=%0d state=%0d busy=%0b want 1/1/0/0",
                               pkt_done_strobe, cnt_fcs_ok, state, rx_busy);
        end
        tick();
        checks++; if (pkt_done_strobe !== 1'b0) begin
            errors++; $display("FAIL good_done_width: done=%0b want 0", pkt_done_strobe);
        end
        checks++; if (rst_seen !== 1'b0) begin
            errors++; $display("FAIL good_no_core_rst: core_rst seen=%0b want 0", rst_seen);
        end
    endtask

    task automatic test_lts_timeout();
        int n;
        bit ok;
        short_preamble_detected = 1'b1;
        tick();
        short_preamble_detected = 1'b0;
        run_samples(160);
        checks++; if (state !== 3'd1) begin
            errors++; $display("FAIL lts_before_timeout: state=%0d want 1", state);
        end
        tick();
        checks++; if (state !== 3'd4 || core_rst !== 1'b1 || abort_code !== 3'd1 || cnt_abort !== 16'd1) begin
            errors++; $display("FAIL lts_abort: state=%0d rst=%0b code=%0d aborts=%0d want 4/1/1/1",
                               state, core_rst, abort_code, cnt_abort);
        end
        n = 0;
        while (core_rst && n < 20) begin
            n++;
            tick();
        end
        checks++; if (n !== 4) begin
            errors++; $display("FAIL lts_rst_width: core_rst high %0d cycles want 4", n);
        end
        checks++; if (state !== 3'd0) begin
            errors++; $display("FAIL lts_idle_on_fall: state=%0d want 0", state);
        end
        wait_idle(ok);
    endtask

    // Long preamble arriving on the exact timeout cycle must win.
    task automatic test_long_beats_timeout();
        short_preamble_detected = 1'b1;
        tick();
        short_preamble_detected = 1'b0;
        run_samples(160);
        long_preamble_detected = 1'b1;
        tick();
        long_preamble_detected = 1'b0;
        checks++; if (state !== 3'd2 || cnt_abort !== 16'd1) begin
            errors++; $display("FAIL long_beats_timeout: state=%0d aborts=%0d want 2/1", state, cnt_abort);
        end
        enable = 1'b0;
        tick();
        enable = 1'b1;
        checks++; if (state !== 3'd0 || core_rst !== 1'b0) begin
            errors++; $display("FAIL disable_hdr_wait: state=%0d rst=%0b want 0/0", state, core_rst);
        end
    endtask

    task automatic test_hdr_rejects();
        logic        v_tab [3] = '{1'b1, 1'b1, 1'b0};
        logic        h_tab [3] = '{1'b0, 1'b1, 1'b0};
        logic [15:0] l_tab [3] = '{16'd5000, 16'd100, 16'd100};
        logic [2:0]  c_tab [3] = '{3'd4, 3'd3, 3'd2};
        bit ok;
        for (int k = 0; k < 3; k++) begin
            go_to_hdr();
            send_header(v_tab[k], h_tab[k], l_tab[k]);
            checks++; if (state !== 3'd4 || core_rst !== 1'b1 || abort_code !== c_tab[k] || cnt_abort !== 16'(2 + k)) begin
                errors++; $display("FAIL hdr_reject_%0d: state=%0d rst=%0b code=%0d aborts=%0d want 4/1/%0d/%0d",
                                   k, state, core_rst, abort_code, cnt_abort, c_tab[k], 2 + k);
            end
            wait_idle(ok);
            checks++; if (!ok) begin
                errors++; $display("FAIL hdr_reject_%0d_idle: state=%0d rst=%0b want idle", k, state, core_rst);
            end
        end
    endtask

    task automatic test_hdr_timeout();
        bit ok;
        go_to_hdr();
        run_samples(200);
        checks++; if (state !== 3'd2) begin
            errors++; $display("FAIL hdr_before_timeout: state=%0d want 2", state);
        end
        tick();
        checks++; if (state !== 3'd4 || abort_code !== 3'd5 || cnt_abort !== 16'd5) begin
            errors++; $display("FAIL hdr_timeout: state=%0d code=%0d aborts=%0d want 4/5/5", state, abort_code, cnt_abort);
        end
        wait_idle(ok);
    endtask

    task automatic test_data_stall();
        bit ok;
        go_to_hdr();
        send_header(1'b1, 1'b0, 16'd100);
        send_bytes(1, 50);
        run_samples(399);
        checks++; if (state !== 3'd3) begin
            errors++; $display("FAIL stall_399: state=%0d want 3", state);
        end
        run_samples(1);
        tick();
        checks++; if (state !== 3'd4 || abort_code !== 3'd6 || cnt_abort !== 16'd6) begin
            errors++; $display("FAIL stall_abort: state=%0d code=%0d aborts=%0d want 4/6/6", state, abort_code, cnt_abort);
        end
        wait_idle(ok);
        byte_count = 16'd0;
        go_to_hdr();
        send_header(1'b1, 1'b0, 16'd100);
        for (int k = 0; k < 3; k++) begin
            run_samples(399);
            send_bytes(k + 1, 1);
        end
        run_samples(399);
        tick();
        checks++; if (state !== 3'd3 || cnt_abort !== 16'd6) begin
            errors++; $display("FAIL bytes_every_399: state=%0d aborts=%0d want 3/6", state, cnt_abort);
        end
        fcs_out_strobe = 1'b1;
        fcs_ok = 1'b0;
        tick();
        fcs_out_strobe = 1'b0;
        checks++; if (cnt_fcs_err !== 16'd1 || cnt_fcs_ok !== 16'd1 || state !== 3'd0) begin
            errors++; $display("FAIL fcs_err_count: err=%0d ok=%0d state=%0d want 1/1/0", cnt_fcs_err, cnt_fcs_ok, state);
        end
    endtask

    task automatic test_len_overrun();
        bit ok;
        byte_count = 16'd0;
        go_to_hdr();
        send_header(1'b1, 1'b0, 16'd10);
        send_bytes(14, 1);
        checks++; if (state !== 3'd3) begin
            errors++; $display("FAIL overrun_edge: state=%0d want 3 at count 14", state);
        end
        send_bytes(15, 1);
        checks++; if (state !== 3'd4 || abort_code !== 3'd7 || cnt_abort !== 16'd7) begin
            errors++; $display("FAIL overrun_abort: state=%0d code=%0d aborts=%0d want 4/7/7", state, abort_code, cnt_abort);
        end
        wait_idle(ok);
        byte_count = 16'd0;
    endtask

    task automatic test_simultaneous();
        rst_seen = 1'b0;
        go_to_hdr();
        send_header(1'b1, 1'b0, 16'd100);
        run_samples(400);
        fcs_out_strobe = 1'b1;
        fcs_ok = 1'b1;
        tick();
        fcs_out_strobe = 1'b0;
        checks++; if (state !== 3'd0 || pkt_done_strobe !== 1'b1 || cnt_fcs_ok !== 16'd2 || cnt_abort !== 16'd7 || rst_seen !== 1'b0) begin
            errors++; $display("FAIL fcs_beats_timeout: state=%0d done=%0b ok=%0d aborts=%0d rst_seen=%0b want 0/1/2/7/0",
                               state, pkt_done_strobe, cnt_fcs_ok, cnt_abort, rst_seen);
        end
        go_to_hdr();
        send_header(1'b1, 1'b0, 16'd20);
        fcs_out_strobe = 1'b1;
        fcs_ok = 1'b1;
        clear_cnt = 1'b1;
        tick();
        fcs_out_strobe = 1'b0;
        clear_cnt = 1'b0;
        checks++; if (cnt_fcs_ok !== 16'd0 || cnt_fcs_err !== 16'd0 || cnt_abort !== 16'd0 || pkt_done_strobe !== 1'b1) begin
            errors++; $display("FAIL clear_wins: ok=%0d err=%0d aborts=%0d done=%0b want 0/0/0/1",
                               cnt_fcs_ok, cnt_fcs_err, cnt_abort, pkt_done_strobe);
        end
    endtask

    task automatic test_enable_and_async_reset();
        go_to_hdr();
        send_header(1'b0, 1'b0, 16'd100);
        tick();
        checks++; if (state !== 3'd4 || core_rst !== 1'b1 || abort_code !== 3'd2 || cnt_abort !== 16'd1) begin
            errors++; $display("FAIL enable_setup: state=%0d rst=%0b code=%0d aborts=%0d want 4/1/2/1",
                               state, core_rst, abort_code, cnt_abort);
        end
        enable = 1'b0;
        tick();
        enable = 1'b1;
        checks++; if (state !== 3'd0 || core_rst !== 1'b0 || rx_busy !== 1'b0 || cnt_abort !== 16'd1) begin
            errors++; $display("FAIL enable_drop_in_reset: state=%0d rst=%0b busy=%0b aborts=%0d want 0/0/0/1",
                               state, core_rst, rx_busy, cnt_abort);
        end
        byte_count = 16'd0;
        go_to_hdr();
        send_header(1'b1, 1'b0, 16'd100);
        send_bytes(1, 10);
        #3 rst_n = 1'b0;
        #1;
        checks++; if ({state, core_rst, rx_busy, abort_code, pkt_done_strobe} !== 9'd0 ||
                      {cnt_fcs_ok, cnt_fcs_err, cnt_abort} !== 48'd0) begin
            errors++; $display("FAIL async_reset: state=%0d rst=%0b busy=%0b code=%0d aborts=%0d want all 0",
                               state, core_rst, rx_busy, abort_code, cnt_abort);
        end
        #2 rst_n = 1'b1;
        rst_seen = 1'b0;
        repeat (6) tick();
        checks++; if (state !== 3'd0 || rst_seen !== 1'b0) begin
            errors++; $display("FAIL after_async_reset: state=%0d rst_seen=%0b want 0/0", state, rst_seen);
        end
    endtask

    initial begin
        test_reset();
        test_good_packet();
        test_lts_timeout();
        test_long_beats_timeout();
        test_hdr_rejects();
        test_hdr_timeout();
        test_data_stall();
        test_len_overrun();
        test_simultaneous();
        test_enable_and_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
